// File: rtl/bcd_pkg.sv
// Shared constants for the keypad BCD entry path: digit limits and FSM encoding.
package bcd_pkg;

  localparam int        NIB     = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ENTRY = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ENTRY = ST_ENTRY,
    S_DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/bcd_digit_entry_if.sv
// Key inputs and entry/commit outputs of the decimal entry stage.
interface bcd_digit_entry_if #(
  parameter int K = 2
);
  import bcd_pkg::*;

  localparam int CW = $clog2(K + 1);

  logic               digit_valid;
  logic [NIB-1:0]     digit;
  logic               enter;
  logic               clear;
  logic [K*NIB-1:0]   bcd_work;
  logic [K*NIB-1:0]   bcd_out;
  logic               bcd_valid;
  logic [CW-1:0]      count;
  logic               error;

  modport slave (
    input  digit_valid, digit, enter, clear,
    output bcd_work, bcd_out, bcd_valid, count, error
  );

  modport master (
    output digit_valid, digit, enter, clear,
    input  bcd_work, bcd_out, bcd_valid, count, error
  );

endinterface

// File: rtl/rise_edge_detect.sv
// Registered 0->1 detector: one pulse per rising level, seen on the clock it rises.
module rise_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic pulse_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= level_i;
  end

  assign pulse_o = level_i & ~prev_q;

endmodule

// File: rtl/bcd_digit_entry.sv
// Calculator-style decimal entry: shifts digits in at the LSD, commits a packed-BCD
// word on ENTER with a one-cycle valid strobe, and flags bad or surplus digits.
module bcd_digit_entry
  import bcd_pkg::*;
#(
  parameter int K = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_digit_entry_if.slave      bus
);

  localparam int              CW    = $clog2(K + 1);
  localparam logic [CW-1:0]   K_CNT = CW'(K);

  logic dig_ev, ent_ev, clr_ev;

  rise_edge_detect u_dig (.clk(clk), .rst_n(rst_n), .level_i(bus.digit_valid), .pulse_o(dig_ev));
  rise_edge_detect u_ent (.clk(clk), .rst_n(rst_n), .level_i(bus.enter),       .pulse_o(ent_ev));
  rise_edge_detect u_clr (.clk(clk), .rst_n(rst_n), .level_i(bus.clear),       .pulse_o(clr_ev));

  state_t             state_q, state_d;
  logic [K*NIB-1:0]   work_q,  work_d;
  logic [K*NIB-1:0]   out_q,   out_d;
  logic [CW-1:0]      count_q, count_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;

  logic [K*NIB+NIB-1:0] shift_ext;
  assign shift_ext = {work_q, bus.digit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      out_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      out_q   <= out_d;
      count_q <= count_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  // Priority clear > enter > digit; losing events on the same clock are dropped.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    out_d   = out_q;
    count_d = count_q;
    valid_d = 1'b0;
    error_d = 1'b0;

    if (clr_ev) begin
      work_d  = '0;
      count_d = '0;
      state_d = S_IDLE;
    end else if (ent_ev) begin
      out_d   = work_q;
      valid_d = 1'b1;
      state_d = S_DONE;
    end else if (dig_ev) begin
      if (bus.digit > BCD_MAX) begin
        error_d = 1'b1;
      end else begin
        case (state_q)
          S_DONE: begin
            work_d          = '0;
            work_d[NIB-1:0] = bus.digit;
            count_d         = CW'(1);
            state_d         = S_ENTRY;
          end
          default: begin
            if (count_q == K_CNT) begin
              error_d = 1'b1;
            end else begin
              work_d  = shift_ext[K*NIB-1:0];
              count_d = count_q + 1'b1;
              state_d = S_ENTRY;
            end
          end
        endcase
      end
    end
  end

  assign bus.bcd_work  = work_q;
  assign bus.bcd_out   = out_q;
  assign bus.bcd_valid = valid_q;
  assign bus.count     = count_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Directed bench for bcd_digit_entry (K=2) with a decimal model of the downstream converter.
module tb_bcd_digit_entry;

  localparam int K = 2;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  bcd_digit_entry_if #(.K(K)) bus ();

  bcd_digit_entry #(.K(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bcd2bin(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // press a digit; returns error/valid seen on the cycle after the rising edge
  task automatic press(input logic [3:0] d, output logic err, output logic vld);
    bus.digit       = d;
    bus.digit_valid = 1'b1;
    tick();
    err = bus.error;
    vld = bus.bcd_valid;
    bus.digit_valid = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    if (bus.bcd_work !== 8'h00) begin n_total++; $display("FAIL reset_work: got %0h expected 0", bus.bcd_work); end
    else begin n_total++; n_pass++; end
    if (bus.bcd_out !== 8'h00) begin n_total++; $display("FAIL reset_out: got %0h expected 0", bus.bcd_out); end
    else begin n_total++; n_pass++; end
    if (bus.count !== 2'd0) begin n_total++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    else begin n_total++; n_pass++; end
    if ({bus.bcd_valid, bus.error} !== 2'b00) begin n_total++; $display("FAIL reset_pulses: got %b expected 00", {bus.bcd_valid, bus.error}); end
    else begin n_total++; n_pass++; end
  endtask

  task automatic test_commit();
    logic e, v;
    press(4'd4, e, v);
    chk("commit_press4_err", int'(e), 0);
    press(4'd7, e, v);
    chk("commit_work", int'(bus.bcd_work), 'h47);
    chk("commit_count", int'(bus.count), 2);
    bus.enter = 1'b1;
    tick();
    chk("commit_valid", int'(bus.bcd_valid), 1);
    chk("commit_out", int'(bus.bcd_out), 'h47);
    chk("commit_bin", bcd2bin(bus.bcd_out), 47);
    chk("commit_no_err", int'(bus.error), 0);
    bus.enter = 1'b0;
    tick();
    chk("commit_valid_1cyc", int'(bus.bcd_valid), 0);
    // enter again while DONE re-commits the same word
    bus.enter = 1'b1;
    tick();
    chk("recommit_valid", int'(bus.bcd_valid), 1);
    chk("recommit_out", int'(bus.bcd_out), 'h47);
    bus.enter = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    logic e, v;
    do_clear();
    press(4'd1, e, v);
    press(4'd2, e, v);
    press(4'd3, e, v);
    chk("ovf_err", int'(e), 1);
    chk("ovf_work", int'(bus.bcd_work), 'h12);
    chk("ovf_count", int'(bus.count), 2);
    chk("ovf_err_1cyc", int'(bus.error), 0);
    bus.enter = 1'b1;
    tick();
    chk("ovf_commit_out", int'(bus.bcd_out), 'h12);
    chk("ovf_commit_valid", int'(bus.bcd_valid), 1);
    chk("ovf_commit_bin", bcd2bin(bus.bcd_out), 12);
    bus.enter = 1'b0;
    tick();
  endtask

  task automatic test_bad_digit();
    logic e, v;
    do_clear();
    press(4'd1, e, v);
    press(4'hB, e, v);
    chk("bad_err", int'(e), 1);
    chk("bad_no_valid", int'(v), 0);
    chk("bad_work", int'(bus.bcd_work), 'h01);
    chk("bad_count", int'(bus.count), 1);
    press(4'hF, e, v);
    chk("bad_f_err", int'(e), 1);
    chk("bad_f_work", int'(bus.bcd_work), 'h01);
  endtask

  task automatic test_hold();
    do_clear();
    bus.digit       = 4'd5;
    bus.digit_valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    bus.digit_valid = 1'b0;
    tick();
    chk("hold_work", int'(bus.bcd_work), 'h05);
    chk("hold_count", int'(bus.count), 1);
  endtask

  task automatic test_clear_enter();
    logic e, v;
    do_clear();
    press(4'd0, e, v);
    press(4'd9, e, v);
    chk("clrent_pre_work", int'(bus.bcd_work), 'h09);
    bus.clear = 1'b1;
    bus.enter = 1'b1;
    tick();
    chk("clrent_no_valid", int'(bus.bcd_valid), 0);
    chk("clrent_work", int'(bus.bcd_work), 0);
    chk("clrent_count", int'(bus.count), 0);
    chk("clrent_out_kept", int'(bus.bcd_out), 'h12);
    bus.clear = 1'b0;
    bus.enter = 1'b0;
    tick();
  endtask

  task automatic test_enter_beats_digit();
    logic e, v;
    press(4'd3, e, v);
    bus.digit       = 4'd8;
    bus.digit_valid = 1'b1;
    bus.enter       = 1'b1;
    tick();
    chk("ent_dig_valid", int'(bus.bcd_valid), 1);
    chk("ent_dig_out", int'(bus.bcd_out), 'h03);
    chk("ent_dig_work", int'(bus.bcd_work), 'h03);
    chk("ent_dig_count", int'(bus.count), 1);
    bus.digit_valid = 1'b0;
    bus.enter       = 1'b0;
    tick();
  endtask

  task automatic test_done_restart();
    logic e, v;
    do_clear();
    press(4'd4, e, v);
    press(4'd7, e, v);
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    tick();
    press(4'd3, e, v);
    chk("restart_work", int'(bus.bcd_work), 'h03);
    chk("restart_count", int'(bus.count), 1);
    chk("restart_out", int'(bus.bcd_out), 'h47);
    bus.digit       = 4'd6;
    bus.digit_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_work", int'(bus.bcd_work), 0);
    chk("midrst_out", int'(bus.bcd_out), 0);
    chk("midrst_count", int'(bus.count), 0);
    chk("midrst_pulses", int'({bus.bcd_valid, bus.error}), 0);
    bus.digit_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    chk("postrst_work", int'(bus.bcd_work), 0);
  endtask

  initial begin
    n_pass          = 0;
    n_total         = 0;
    rst_n           = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit       = 4'd0;
    bus.enter       = 1'b0;
    bus.clear       = 1'b0;
    tick();
    tick();
    test_reset();
    #2;
    rst_n = 1'b1;
    tick();
    test_commit();
    test_overflow();
    test_bad_digit();
    test_hold();
    test_clear_enter();
    test_enter_beats_digit();
    test_done_restart();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
